// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI mode-0 slave that writes 32-bit framed commands into a 16x16 register bank.
module spi_slave_regfile #(
    parameter logic [11:0] HEADER      = 12'h001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk_in,
    input  logic        cs_n_in,
    input  logic        mosi_in,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        wr_valid,
    output logic [3:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);

    typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT, DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_arm;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;
    logic [30:0]            r_shift;
    logic [5:0]             r_count;
    logic [15:0]            r_bank [16];
    logic [15:0]            r_rd_data;
    logic                   r_wr_valid;
    logic [3:0]             r_wr_addr;
    logic [15:0]            r_wr_data;
    logic                   r_frame_err;

    logic        w_sclk;
    logic        w_cs_n;
    logic        w_mosi;
    logic        w_rise;
    logic        w_cs_fall;
    logic [31:0] w_frame;
    logic        w_hdr_ok;
    logic        w_shift_en;
    logic        w_clear;
    logic        w_commit;
    logic        w_abort;

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk & ~r_sclk_prev;
    assign w_cs_fall = ~w_cs_n & r_cs_prev;
    assign w_frame   = {r_shift, w_mosi};
    assign w_hdr_ok  = (w_frame[31:20] == HEADER);

    // r_arm fills with ones as real pin values reach the last sync stage, so the
    // reset value of the cs_n chain is never mistaken for an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_arm       <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
            r_arm       <= {r_arm[SYNC_STAGES-2:0], 1'b1};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_clear     = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            WAIT_HI: begin
                if (r_arm[SYNC_STAGES-1] && w_cs_n) w_state_nxt = IDLE;
            end
            IDLE: begin
                w_clear = 1'b1;
                if (w_cs_fall) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                // A final edge coinciding with cs_n rising still completes the frame.
                if (w_rise && (r_count == 6'd31)) begin
                    w_shift_en  = 1'b1;
                    w_commit    = 1'b1;
                    w_state_nxt = w_cs_n ? IDLE : DONE;
                end else if (w_cs_n) begin
                    w_abort     = (r_count != 6'd0);
                    w_state_nxt = IDLE;
                end else if (w_rise) begin
                    w_shift_en = 1'b1;
                end
            end
            DONE: begin
                if (w_cs_n) w_state_nxt = IDLE;
            end
            default: w_state_nxt = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_count     <= '0;
            r_wr_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_data   <= '0;
            for (int i = 0; i < 16; i++) r_bank[i] <= '0;
        end else begin
            if (w_clear) begin
                r_shift <= '0;
                r_count <= '0;
            end else if (w_shift_en) begin
                r_shift <= w_frame[30:0];
                r_count <= r_count + 6'd1;
            end
            r_wr_valid  <= w_commit & w_hdr_ok;
            r_frame_err <= w_abort | (w_commit & ~w_hdr_ok);
            if (w_commit && w_hdr_ok) begin
                r_wr_addr                 <= w_frame[19:16];
                r_wr_data                 <= w_frame[15:0];
                r_bank[w_frame[19:16]]    <= w_frame[15:0];
            end
            r_rd_data <= r_bank[rd_addr];
        end
    end

    assign rd_data   = r_rd_data;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb/tb_spi_slave_regfile.sv - directed frames against a frame-level register bank model.
module tb_spi_slave_regfile;

    localparam logic [11:0] HEADER      = 12'h001;
    localparam int          SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk_in = 1'b0;
    logic        cs_n_in = 1'b1;
    logic        mosi_in = 1'b0;
    logic [3:0]  rd_addr = 4'd0;
    logic [15:0] rd_data;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;

    spi_slave_regfile #(.HEADER(HEADER), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .cs_n_in(cs_n_in), .mosi_in(mosi_in),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Frame-level model: bank contents and expected pulse totals.
    logic [15:0] m_bank [16];
    int          m_wv = 0;
    int          m_fe = 0;
    logic [3:0]  m_wr_addr = 4'd0;
    logic [15:0] m_wr_data = 16'd0;

    int          n_wv = 0;
    int          n_fe = 0;
    logic        chk = 1'b0;
    logic [3:0]  a_q = 4'd0;

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_bank[i] = 16'h0000;
        m_wr_addr = 4'd0;
        m_wr_data = 16'd0;
    endfunction

    function automatic void model_frame(input logic [31:0] w, input int nbits);
        if (nbits >= 32 && w[31:20] == HEADER) begin
            m_bank[w[19:16]] = w[15:0];
            m_wr_addr = w[19:16];
            m_wr_data = w[15:0];
            m_wv++;
        end else if (nbits >= 32 || nbits > 0) begin
            m_fe++;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) a_q = rd_addr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid) n_wv++;
            if (frame_err) n_fe++;
            vectors++;
            if (wr_valid && frame_err) begin
                miscompares++;
                $display("FAIL pulse_exclusive: wr_valid=%0b frame_err=%0b", wr_valid, frame_err);
            end
            if (chk) begin
                vectors++;
                if (rd_data !== m_bank[a_q]) begin
                    miscompares++;
                    $display("FAIL rd_data[%0d]: got %0h expected %0h", a_q, rd_data, m_bank[a_q]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        mosi_in = b;
        tick(4);
        sclk_in = 1'b1;
        tick(4);
        sclk_in = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) spi_bit(w[31-i]);
    endtask

    task automatic cs_low();
        cs_n_in = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        cs_n_in = 1'b1;
        tick(8);
    endtask

    task automatic send_frame(input logic [31:0] w);
        cs_low();
        send_bits(w, 32);
        tick(4);
        cs_high();
        model_frame(w, 32);
    endtask

    task automatic read_sweep();
        chk = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd_addr = a[3:0];
            tick(1);
        end
        tick(1);
        chk = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_wv_count"}, n_wv, m_wv);
        check({tag, "_fe_count"}, n_fe, m_fe);
        check({tag, "_wr_addr"}, {28'd0, wr_addr}, {28'd0, m_wr_addr});
        check({tag, "_wr_data"}, {16'd0, wr_data}, {16'd0, m_wr_data});
        read_sweep();
    endtask

    task automatic read_lit(input string name, input logic [3:0] a, input logic [15:0] exp);
        rd_addr = a;
        tick(1);
        check(name, {16'd0, rd_data}, {16'd0, exp});
    endtask

    initial begin
        int          lat;
        int          wv0;
        int          fe0;
        logic [31:0] w;

        model_clear();
        tick(4);
        check("reset_rd_data", {16'd0, rd_data}, 32'd0);
        check("reset_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_wr_addr", {28'd0, wr_addr}, 32'd0);
        check("reset_wr_data", {16'd0, wr_data}, 32'd0);
        rst_n = 1'b1;
        tick(10);
        check_model("reset");

        // Basic frame with exact write latency measured on the 32nd edge.
        w = 32'h0015_A5C3;
        wv0 = n_wv;
        cs_low();
        send_bits(w, 31);
        mosi_in = w[0];
        tick(4);
        sclk_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr_valid && lat == 0) lat = k;
        end
        @(posedge clk);
        #1;
        sclk_in = 1'b0;
        tick(4);
        cs_high();
        model_frame(w, 32);
        check("basic_latency", lat, SYNC_STAGES + 1);
        check("basic_wv_pulses", n_wv - wv0, 1);
        check("basic_wr_addr", {28'd0, wr_addr}, 32'd5);
        check("basic_wr_data", {16'd0, wr_data}, 32'h0000_A5C3);
        read_lit("basic_rd5", 4'd5, 16'hA5C3);
        check_model("basic");

        wv0 = n_wv; fe0 = n_fe;
        send_frame(32'h0023_1234);
        check("badhdr_fe_pulses", n_fe - fe0, 1);
        check("badhdr_wv_pulses", n_wv - wv0, 0);
        read_lit("badhdr_rd3", 4'd3, 16'h0000);
        check_model("badhdr");

        fe0 = n_fe;
        cs_low();
        send_bits(32'h001F_FFFF, 20);
        tick(4);
        cs_high();
        model_frame(32'h001F_FFFF, 20);
        check("trunc_fe_pulses", n_fe - fe0, 1);
        read_lit("trunc_rd15", 4'd15, 16'h0000);
        send_frame(32'h001F_0001);
        read_lit("trunc_next_rd15", 4'd15, 16'h0001);
        check_model("trunc");

        wv0 = n_wv;
        cs_low();
        send_bits(32'h0017_BEEF, 32);
        send_bits(32'hF000_0000, 4);
        tick(4);
        cs_high();
        model_frame(32'h0017_BEEF, 32);
        check("extra_wv_pulses", n_wv - wv0, 1);
        read_lit("extra_rd7", 4'd7, 16'hBEEF);
        check_model("extra");

        // Reset in the middle of a frame; the tail of that frame must be ignored.
        wv0 = n_wv; fe0 = n_fe;
        w = 32'h0016_DEAD;
        cs_low();
        send_bits(w, 10);
        rst_n = 1'b0;
        tick(3);
        model_clear();
        rst_n = 1'b1;
        w = w << 10;
        send_bits(w, 22);
        tick(4);
        cs_high();
        check("rstmid_wv_pulses", n_wv - wv0, 0);
        check("rstmid_fe_pulses", n_fe - fe0, 0);
        read_lit("rstmid_rd5", 4'd5, 16'h0000);
        read_lit("rstmid_rd6", 4'd6, 16'h0000);
        send_frame(32'h0010_0042);
        read_lit("rstmid_rd0", 4'd0, 16'h0042);
        check_model("rstmid");

        wv0 = n_wv;
        for (int a = 0; a < 16; a++) begin
            logic [15:0] d;
            d = 16'h1000 + 16'(a);
            send_frame({HEADER, a[3:0], d});
        end
        check("b2b_wv_pulses", n_wv - wv0, 16);
        read_lit("b2b_rd0", 4'd0, 16'h1000);
        read_lit("b2b_rd9", 4'd9, 16'h1009);
        read_lit("b2b_rd15", 4'd15, 16'h100F);
        check_model("b2b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
